// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, FSM states and frame limits.
// Intended for reuse by a matching configurable receiver.
package uart_pkg;

  localparam int MIN_DATA = 5;
  localparam int MIN_CPB  = 2;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // 2'b11 is an alias for "no parity"
  function automatic logic par_enabled(input logic [1:0] p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side handshake and frame-format bundle for the configurable UART transmitter.
interface uart_tx_cfg_if #(
  parameter int DIV_W    = 16,
  parameter int MAX_DATA = 9
) ();
  logic [DIV_W-1:0]    i_Clks_Per_Bit;
  logic [3:0]          i_Data_Bits;
  logic [1:0]          i_Parity;
  logic                i_Two_Stop;
  logic                i_Tx_DV;
  logic [MAX_DATA-1:0] i_Tx_Data;
  logic                o_Tx_Ready;
  logic                o_Tx_Serial;
  logic                o_Tx_Active;
  logic                o_Tx_Done;

  modport slave (
    input  i_Clks_Per_Bit, i_Data_Bits, i_Parity, i_Two_Stop, i_Tx_DV, i_Tx_Data,
    output o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
  );

  modport master (
    output i_Clks_Per_Bit, i_Data_Bits, i_Parity, i_Two_Stop, i_Tx_DV, i_Tx_Data,
    input  o_Tx_Ready, o_Tx_Serial, o_Tx_Active, o_Tx_Done
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter producing a one-cycle bit_end strobe every (load_val+1) cycles.
module uart_bit_timer #(
  parameter int DIV_W = 16
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_bit_end
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] per_q, per_d;

  assign o_bit_end = i_en && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    per_d = per_q;
    if (i_load) begin
      cnt_d = i_load_val;
      per_d = i_load_val;
    end else if (i_en) begin
      cnt_d = (cnt_q == '0) ? per_q : cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      cnt_q <= '0;
      per_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      per_q <= per_d;
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, 5..MAX_DATA data bits LSB-first, optional parity,
// 1/2 stop bits, with a one-entry holding register for gap-free back-to-back frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DIV_W    = 16,
  parameter int MAX_DATA = 9
) (
  input logic          i_Clock,
  input logic          i_Rst_n,
  uart_tx_cfg_if.slave tx
);

  tx_state_e           state_q, state_d;
  logic                serial_q, serial_d;
  logic                active_q, active_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;

  logic                hold_full_q, hold_full_d;
  logic [MAX_DATA-1:0] hold_data_q, hold_data_d;
  logic [DIV_W-1:0]    hold_cpbm1_q, hold_cpbm1_d;
  logic [3:0]          hold_dbits_q, hold_dbits_d;
  logic                hold_par_en_q, hold_par_en_d;
  logic                hold_odd_q, hold_odd_d;
  logic                hold_two_q, hold_two_d;

  logic [MAX_DATA-1:0] shift_q, shift_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [3:0]          dbits_q, dbits_d;
  logic                par_en_q, par_en_d;
  logic                par_acc_q, par_acc_d;
  logic                two_stop_q, two_stop_d;
  logic                stop_cnt_q, stop_cnt_d;

  logic                accept, xfer, bit_end;
  logic [DIV_W-1:0]    cpb_in;
  logic [3:0]          dbits_in;

  uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
    .i_Clock    (i_Clock),
    .i_Rst_n    (i_Rst_n),
    .i_load     (xfer),
    .i_load_val (hold_cpbm1_q),
    .i_en       (active_q),
    .o_bit_end  (bit_end)
  );

  always_comb begin
    cpb_in = (tx.i_Clks_Per_Bit < DIV_W'(MIN_CPB)) ? DIV_W'(MIN_CPB) : tx.i_Clks_Per_Bit;
    if (tx.i_Data_Bits < 4'(MIN_DATA))      dbits_in = 4'(MIN_DATA);
    else if (tx.i_Data_Bits > 4'(MAX_DATA)) dbits_in = 4'(MAX_DATA);
    else                                    dbits_in = tx.i_Data_Bits;
  end

  always_comb begin
    state_d    = state_q;
    serial_d   = serial_q;
    active_d   = active_q;
    done_d     = 1'b0;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    dbits_d    = dbits_q;
    par_en_d   = par_en_q;
    par_acc_d  = par_acc_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    xfer       = 1'b0;

    case (state_q)
      ST_IDLE: if (hold_full_q) xfer = 1'b1;
      ST_START: if (bit_end) begin
        state_d  = ST_DATA;
        serial_d = shift_q[0];
      end
      ST_DATA: if (bit_end) begin
        par_acc_d = par_acc_q ^ shift_q[0];
        if (bit_cnt_q == dbits_q - 4'd1) begin
          if (par_en_q) begin
            state_d  = ST_PARITY;
            serial_d = par_acc_q ^ shift_q[0];
          end else begin
            state_d  = ST_STOP;
            serial_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          shift_d   = shift_q >> 1;
          serial_d  = shift_q[1];
        end
      end
      ST_PARITY: if (bit_end) begin
        state_d  = ST_STOP;
        serial_d = 1'b1;
      end
      ST_STOP: if (bit_end) begin
        if (two_stop_q && !stop_cnt_q) begin
          stop_cnt_d = 1'b1;
        end else begin
          done_d = 1'b1;
          if (hold_full_q) begin
            xfer = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
            serial_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start: holding register moves into the shifter and the bit timer restarts
    if (xfer) begin
      state_d    = ST_START;
      serial_d   = 1'b0;
      active_d   = 1'b1;
      shift_d    = hold_data_q;
      dbits_d    = hold_dbits_q;
      par_en_d   = hold_par_en_q;
      par_acc_d  = hold_odd_q;
      two_stop_d = hold_two_q;
      bit_cnt_d  = 4'd0;
      stop_cnt_d = 1'b0;
    end

    accept        = tx.i_Tx_DV && ready_q;
    hold_full_d   = (hold_full_q && !xfer) || accept;
    hold_data_d   = hold_data_q;
    hold_cpbm1_d  = hold_cpbm1_q;
    hold_dbits_d  = hold_dbits_q;
    hold_par_en_d = hold_par_en_q;
    hold_odd_d    = hold_odd_q;
    hold_two_d    = hold_two_q;
    if (accept) begin
      hold_data_d   = tx.i_Tx_Data;
      hold_cpbm1_d  = cpb_in - 1'b1;
      hold_dbits_d  = dbits_in;
      hold_par_en_d = par_enabled(tx.i_Parity);
      hold_odd_d    = (tx.i_Parity == PAR_ODD);
      hold_two_d    = tx.i_Two_Stop;
    end
    ready_d = !hold_full_d;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q       <= ST_IDLE;
      serial_q      <= 1'b1;
      active_q      <= 1'b0;
      done_q        <= 1'b0;
      ready_q       <= 1'b1;
      hold_full_q   <= 1'b0;
      hold_data_q   <= '0;
      hold_cpbm1_q  <= DIV_W'(MIN_CPB - 1);
      hold_dbits_q  <= 4'(MIN_DATA);
      hold_par_en_q <= 1'b0;
      hold_odd_q    <= 1'b0;
      hold_two_q    <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= 4'd0;
      dbits_q       <= 4'(MIN_DATA);
      par_en_q      <= 1'b0;
      par_acc_q     <= 1'b0;
      two_stop_q    <= 1'b0;
      stop_cnt_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      serial_q      <= serial_d;
      active_q      <= active_d;
      done_q        <= done_d;
      ready_q       <= ready_d;
      hold_full_q   <= hold_full_d;
      hold_data_q   <= hold_data_d;
      hold_cpbm1_q  <= hold_cpbm1_d;
      hold_dbits_q  <= hold_dbits_d;
      hold_par_en_q <= hold_par_en_d;
      hold_odd_q    <= hold_odd_d;
      hold_two_q    <= hold_two_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      dbits_q       <= dbits_d;
      par_en_q      <= par_en_d;
      par_acc_q     <= par_acc_d;
      two_stop_q    <= two_stop_d;
      stop_cnt_q    <= stop_cnt_d;
    end
  end

  assign tx.o_Tx_Serial = serial_q;
  assign tx.o_Tx_Active = active_q;
  assign tx.o_Tx_Done   = done_q;
  assign tx.o_Tx_Ready  = ready_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: expected line waveforms are hand-written strings in
// transmit order (start, data LSB-first, parity, stop), each char held CPB cycles.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  uart_tx_cfg_if #(.DIV_W(16), .MAX_DATA(9)) tx_if ();

  uart_tx_cfg #(.DIV_W(16), .MAX_DATA(9)) dut (
    .i_Clock (clk),
    .i_Rst_n (rst_n),
    .tx      (tx_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_cfg(input int cpb, input int db, input logic [1:0] par, input logic two);
    tx_if.i_Clks_Per_Bit = 16'(cpb);
    tx_if.i_Data_Bits    = 4'(db);
    tx_if.i_Parity       = par;
    tx_if.i_Two_Stop     = two;
  endtask

  // Returns just after the accepting edge
  task automatic send(input string tag, input logic [8:0] d);
    int t;
    @(negedge clk);
    tx_if.i_Tx_DV   = 1'b1;
    tx_if.i_Tx_Data = d;
    t = 0;
    while (!tx_if.o_Tx_Ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 tx_if.i_Tx_DV = 1'b0;
  endtask

  // Checks every cycle of one frame; first negedge sampled is the frame's first cycle
  task automatic check_frame(input string tag, input string bits, input int cpb, input logic first_done);
    logic exp_bit;
    for (int k = 0; k < bits.len(); k++) begin
      for (int j = 0; j < cpb; j++) begin
        @(negedge clk);
        exp_bit = (bits[k] == 8'h31);
        chk($sformatf("%s_ser_b%0d_c%0d", tag, k, j), 32'(tx_if.o_Tx_Serial), 32'(exp_bit));
        chk($sformatf("%s_act_b%0d_c%0d", tag, k, j), 32'(tx_if.o_Tx_Active), 32'd1);
        chk($sformatf("%s_done_b%0d_c%0d", tag, k, j), 32'(tx_if.o_Tx_Done),
            (k == 0 && j == 0) ? 32'(first_done) : 32'd0);
      end
    end
  endtask

  task automatic end_idle(input string tag);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(tx_if.o_Tx_Done), 32'd1);
    chk({tag, "_end_act"},    32'(tx_if.o_Tx_Active), 32'd0);
    chk({tag, "_end_ser"},    32'(tx_if.o_Tx_Serial), 32'd1);
    chk({tag, "_end_rdy"},    32'(tx_if.o_Tx_Ready), 32'd1);
    @(negedge clk);
    chk({tag, "_done_drop"},  32'(tx_if.o_Tx_Done), 32'd0);
  endtask

  task automatic single(input string tag, input logic [8:0] d, input string bits, input int cpb);
    send(tag, d);
    @(negedge clk);
    chk({tag, "_rdy_lo"},   32'(tx_if.o_Tx_Ready), 32'd0);
    chk({tag, "_pre_ser"},  32'(tx_if.o_Tx_Serial), 32'd1);
    chk({tag, "_pre_act"},  32'(tx_if.o_Tx_Active), 32'd0);
    check_frame(tag, bits, cpb, 1'b0);
    end_idle(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tx_if.i_Tx_DV   = 1'b0;
    tx_if.i_Tx_Data = '0;
    set_cfg(4, 8, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_ser",  32'(tx_if.o_Tx_Serial), 32'd1);
    chk("rst_rdy",  32'(tx_if.o_Tx_Ready), 32'd1);
    chk("rst_act",  32'(tx_if.o_Tx_Active), 32'd0);
    chk("rst_done", 32'(tx_if.o_Tx_Done), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, CPB=4, 0xA5
    single("8n1_a5", 9'h0A5, "0101001011", 4);

    // 7E2, CPB=3, 0x35; config changed right after accept must not matter
    set_cfg(3, 7, 2'b01, 1'b1);
    send("7e2_35", 9'h035);
    set_cfg(7, 8, 2'b10, 1'b0);
    @(negedge clk);
    check_frame("7e2_35", "01010110011", 3, 1'b0);
    end_idle("7e2_35");

    // 9O1, CPB=5
    set_cfg(5, 9, 2'b10, 1'b0);
    single("9o1_1ff", 9'h1FF, "011111111101", 5);
    single("9o1_100", 9'h100, "000000000101", 5);

    // Clamps: CPB 0 -> 2; data bits 3 -> 5 (parity 11 = none); data bits 15 -> 9
    set_cfg(0, 8, 2'b00, 1'b0);
    single("cpb0", 9'h03C, "0001111001", 2);
    set_cfg(2, 3, 2'b11, 1'b0);
    single("db3", 9'h1F3, "0110011", 2);
    set_cfg(2, 15, 2'b00, 1'b0);
    single("db15", 9'h12D, "01011010011", 2);

    // Back-to-back: second word queued mid-frame, no idle gap between frames
    set_cfg(4, 8, 2'b00, 1'b0);
    send("b2b_55", 9'h055);
    fork
      begin
        @(negedge clk);
        check_frame("b2b_55", "0101010101", 4, 1'b0);
        check_frame("b2b_aa", "0010101011", 4, 1'b1);
        end_idle("b2b_aa");
      end
      begin
        repeat (3) @(negedge clk);
        chk("b2b_rdy_midframe", 32'(tx_if.o_Tx_Ready), 32'd1);
        send("b2b_aa", 9'h0AA);
        @(negedge clk);
        chk("b2b_rdy_full", 32'(tx_if.o_Tx_Ready), 32'd0);
      end
    join

    // Reset mid-DATA with a queued word: line high at once, queued word discarded
    send("rst_f0", 9'h0F0);
    send("rst_0f", 9'h00F);
    repeat (14) @(negedge clk);
    chk("mid_ser_low", 32'(tx_if.o_Tx_Serial), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ser", 32'(tx_if.o_Tx_Serial), 32'd1);
    chk("mid_rst_rdy", 32'(tx_if.o_Tx_Ready), 32'd1);
    chk("mid_rst_act", 32'(tx_if.o_Tx_Active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_act_%0d", i), 32'(tx_if.o_Tx_Active), 32'd0);
      chk($sformatf("post_rst_ser_%0d", i), 32'(tx_if.o_Tx_Serial), 32'd1);
    end
    single("post_rst_a5", 9'h0A5, "0101001011", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
